// File: rtl/hartslag_evaluatie_if.sv
// Beat-count evaluation bus: sample strobe in, average/level results out.
interface hartslag_evaluatie_if;
  logic [7:0] slagen_in;
  logic       slagen_vld;
  logic [7:0] gemiddeld;
  logic       gem_vld;
  logic       gereed;
  logic [1:0] niveau;
  logic       niveau_vld;
  logic       stil;

  modport master (
    output slagen_in, slagen_vld,
    input  gemiddeld, gem_vld, gereed, niveau, niveau_vld, stil
  );

  modport slave (
    input  slagen_in, slagen_vld,
    output gemiddeld, gem_vld, gereed, niveau, niveau_vld, stil
  );
endinterface

// File: rtl/hartslag_evaluatie.sv
// Heart-rate evaluation: moving average over the last 2**DIEPTE_LOG2 windows,
// then RUST/NORMAAL/HOOG classification with hysteresis and confirmation.
// Optional macro HARTSLAG_STIL_EN builds the flat-line (stil) detector;
// without it stil is tied low.
module hartslag_evaluatie #(
  parameter int unsigned DIEPTE_LOG2  = 2,
  parameter int unsigned DREMPEL_LAAG = 10,
  parameter int unsigned DREMPEL_HOOG = 20,
  parameter int unsigned HYST         = 2,
  parameter int unsigned BEVESTIG     = 2
`ifdef HARTSLAG_STIL_EN
  ,
  parameter int unsigned STIL_AANTAL  = 3
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  hartslag_evaluatie_if.slave  bus
);

  localparam int unsigned DIEPTE = 1 << DIEPTE_LOG2;
  localparam int unsigned SOM_W  = 8 + DIEPTE_LOG2;
  localparam int unsigned FILL_W = DIEPTE_LOG2 + 1;
  localparam int unsigned CNT_W  = (BEVESTIG < 2) ? 1 : $clog2(BEVESTIG + 1);

  localparam logic [7:0] HOOG_GR   = 8'(DREMPEL_HOOG);
  localparam logic [7:0] HOOG_HYST = 8'(DREMPEL_HOOG - HYST);
  localparam logic [7:0] LAAG_GR   = 8'(DREMPEL_LAAG);
  localparam logic [7:0] LAAG_HYST = 8'(DREMPEL_LAAG + HYST);

  typedef enum logic [1:0] {
    RUST    = 2'd0,
    NORMAAL = 2'd1,
    HOOG    = 2'd2,
    INIT    = 2'd3
  } niveau_t;

  logic [7:0]             ring_q [DIEPTE];
  logic [DIEPTE_LOG2-1:0] wp_q;
  logic [SOM_W-1:0]       som_q, som_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   gereed_q, gereed_d;
  logic [7:0]             gem_q, gem_d;
  logic                   gem_vld_q;

  niveau_t                niveau_q;
  niveau_t                kand_c;
  niveau_t                pend_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       tel_nieuw_c;
  logic                   niveau_vld_q;

  // Stage 1 next values: replace the oldest sample and update the running sum.
  always_comb begin
    som_d    = som_q + SOM_W'(bus.slagen_in) - SOM_W'(ring_q[wp_q]);
    fill_d   = (fill_q == FILL_W'(DIEPTE)) ? fill_q : fill_q + FILL_W'(1);
    gereed_d = gereed_q | (fill_d == FILL_W'(DIEPTE));
    gem_d    = gereed_d ? 8'(som_d >> DIEPTE_LOG2) : bus.slagen_in;
  end

  // Stage 1 registers: ring buffer, sum, fill level and average.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DIEPTE); i++) ring_q[i] <= '0;
      wp_q      <= '0;
      som_q     <= '0;
      fill_q    <= '0;
      gereed_q  <= 1'b0;
      gem_q     <= '0;
      gem_vld_q <= 1'b0;
    end else begin
      gem_vld_q <= bus.slagen_vld;
      if (bus.slagen_vld) begin
        ring_q[wp_q] <= bus.slagen_in;
        wp_q         <= wp_q + DIEPTE_LOG2'(1);
        som_q        <= som_d;
        fill_q       <= fill_d;
        gereed_q     <= gereed_d;
        gem_q        <= gem_d;
      end
    end
  end

  // Candidate level from the average, widened thresholds when already in RUST/HOOG.
  always_comb begin
    kand_c = NORMAAL;
    if ((gem_q > HOOG_GR) || ((niveau_q == HOOG) && (gem_q > HOOG_HYST)))
      kand_c = HOOG;
    else if ((gem_q < LAAG_GR) || ((niveau_q == RUST) && (gem_q < LAAG_HYST)))
      kand_c = RUST;
    tel_nieuw_c = ((cnt_q != '0) && (kand_c == pend_q)) ? cnt_q + CNT_W'(1) : CNT_W'(1);
  end

  // Stage 2 FSM: load first level directly, later changes need BEVESTIG agreeing evaluations.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      niveau_q     <= INIT;
      pend_q       <= INIT;
      cnt_q        <= '0;
      niveau_vld_q <= 1'b0;
    end else begin
      niveau_vld_q <= gem_vld_q;
      if (gem_vld_q) begin
        case (niveau_q)
          INIT: begin
            if (gereed_q) niveau_q <= kand_c;
            cnt_q <= '0;
          end
          default: begin
            if (kand_c == niveau_q) begin
              cnt_q <= '0;
            end else if (tel_nieuw_c == CNT_W'(BEVESTIG)) begin
              niveau_q <= kand_c;
              cnt_q    <= '0;
            end else begin
              cnt_q  <= tel_nieuw_c;
              pend_q <= kand_c;
            end
          end
        endcase
      end
    end
  end

`ifdef HARTSLAG_STIL_EN
  localparam int unsigned STIL_W = (STIL_AANTAL < 2) ? 1 : $clog2(STIL_AANTAL + 1);

  logic [STIL_W-1:0] nul_q, nul_d;
  logic              stil_q;

  // Saturating count of consecutive zero samples.
  always_comb begin
    nul_d = '0;
    if (bus.slagen_in == 8'd0)
      nul_d = (nul_q == STIL_W'(STIL_AANTAL)) ? nul_q : nul_q + STIL_W'(1);
  end

  // Flat-line flag follows the zero-run count on each accepted sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nul_q  <= '0;
      stil_q <= 1'b0;
    end else if (bus.slagen_vld) begin
      nul_q  <= nul_d;
      stil_q <= (nul_d == STIL_W'(STIL_AANTAL));
    end
  end

  assign bus.stil = stil_q;
`else
  assign bus.stil = 1'b0;
`endif

  assign bus.gemiddeld  = gem_q;
  assign bus.gem_vld    = gem_vld_q;
  assign bus.gereed     = gereed_q;
  assign bus.niveau     = niveau_q;
  assign bus.niveau_vld = niveau_vld_q;

endmodule
